// File: rtl/ps2_pkg.sv
// Shared constants, encodings and the bring-up script ROM for the PS/2 mouse
// init sequencer.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT       = 8'hAA;
  localparam logic [7:0] RSP_ID        = 8'h00;

  localparam int SCRIPT_LEN = 6;

  typedef enum logic {
    KIND_TX = 1'b0,
    KIND_RX = 1'b1
  } step_kind_e;

  typedef enum logic [2:0] {
    ST_SEND    = 3'd0,
    ST_WAIT_TX = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  typedef struct packed {
    step_kind_e kind;
    logic [7:0] data;
  } step_t;

  // Indices past the end read back as step 0 so a stray lookahead is harmless.
  function automatic step_t rom_step(input logic [2:0] idx);
    step_t s;
    case (idx)
      3'd0:    s = step_t'{kind: KIND_TX, data: CMD_RESET};
      3'd1:    s = step_t'{kind: KIND_RX, data: RSP_ACK};
      3'd2:    s = step_t'{kind: KIND_RX, data: RSP_BAT};
      3'd3:    s = step_t'{kind: KIND_RX, data: RSP_ID};
      3'd4:    s = step_t'{kind: KIND_TX, data: CMD_EN_STREAM};
      3'd5:    s = step_t'{kind: KIND_RX, data: RSP_ACK};
      default: s = step_t'{kind: KIND_TX, data: CMD_RESET};
    endcase
    return s;
  endfunction

  function automatic step_kind_e rom_kind(input logic [2:0] idx);
    step_t s;
    s = rom_step(idx);
    return s.kind;
  endfunction

endpackage

// File: rtl/ps2_step_timer.sv
// Per-step watchdog: counts while enabled, flags the last allowed cycle of a step.
module ps2_step_timer #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: runs the reset/enable script with per-step
// timeouts and whole-script retries, then hands the tx/rx pair to the user.
//
//   state      | meaning
//   ST_SEND    | waiting for ps2_tx idle, then strobes the script byte
//   ST_WAIT_TX | waiting for ps2_tx to finish the byte
//   ST_WAIT_RX | waiting for the expected response byte
//   ST_DONE    | script complete, user port owns ps2_tx
//   ST_ERR     | retries exhausted, sticky until reinit/reset
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reinit,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_din,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       user_wr,
  input  logic [7:0] user_din,
  output logic       user_rdy,
  output logic       user_rx_tick,
  output logic [7:0] user_rx_data,
  output logic       init_done,
  output logic       init_err,
  output logic [1:0] retry_cnt
);

  state_e     r_state;
  logic [2:0] r_step;
  logic [1:0] r_retry;
  logic       r_wr;
  logic [7:0] r_tx_byte;

  step_t      w_cur;
  step_kind_e w_nxt_kind;
  logic       w_active, w_expired, w_send, w_tx_ok, w_rx_hit, w_rx_ok;
  logic       w_adv, w_fail, w_reinit, w_clr, w_done;

  assign w_cur      = rom_step(r_step);
  assign w_nxt_kind = rom_kind(r_step + 3'd1);

  assign w_active = (r_state == ST_SEND) || (r_state == ST_WAIT_TX) || (r_state == ST_WAIT_RX);
  assign w_send   = (r_state == ST_SEND) && tx_idle && (w_cur.kind == KIND_TX);
  assign w_tx_ok  = (r_state == ST_WAIT_TX) && tx_done_tick;
  assign w_rx_hit = (r_state == ST_WAIT_RX) && rx_done_tick;
  assign w_rx_ok  = w_rx_hit && (rx_dout == w_cur.data);
  assign w_adv    = w_tx_ok || w_rx_ok;
  // A completing event in the expiry cycle takes precedence over the timeout.
  assign w_fail   = (w_rx_hit && !w_rx_ok) ||
                    (w_expired && w_active && !w_send && !w_tx_ok && !w_rx_hit);
  assign w_reinit = reinit && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_clr    = w_send || w_adv || w_fail || w_reinit;

  ps2_step_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clr    (w_clr),
    .i_en     (w_active),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_SEND;
      r_step    <= '0;
      r_retry   <= '0;
      r_wr      <= 1'b0;
      r_tx_byte <= '0;
    end else begin
      r_wr <= 1'b0;
      if (w_reinit) begin
        r_step  <= '0;
        r_retry <= '0;
        r_state <= ST_SEND;
      end else if (w_send) begin
        r_wr      <= 1'b1;
        r_tx_byte <= w_cur.data;
        r_state   <= ST_WAIT_TX;
      end else if (w_adv) begin
        if (r_step == 3'(SCRIPT_LEN - 1)) begin
          r_state <= ST_DONE;
        end else begin
          r_step  <= r_step + 3'd1;
          r_state <= (w_nxt_kind == KIND_TX) ? ST_SEND : ST_WAIT_RX;
        end
      end else if (w_fail) begin
        if (r_retry < 2'(MAX_RETRY)) begin
          r_retry <= r_retry + 2'd1;
          r_step  <= '0;
          r_state <= ST_SEND;
        end else begin
          r_state <= ST_ERR;
        end
      end
    end
  end

  assign w_done = (r_state == ST_DONE);

  // Once initialised the user path is combinational so a request is seen the same cycle.
  assign wr_ps2       = w_done ? (user_wr && tx_idle) : r_wr;
  assign tx_din       = w_done ? user_din : r_tx_byte;
  assign user_rdy     = w_done && tx_idle;
  assign user_rx_tick = w_done && rx_done_tick;
  assign user_rx_data = rx_dout;
  assign init_done    = w_done;
  assign init_err     = (r_state == ST_ERR);
  assign retry_cnt    = r_retry;

endmodule
